button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Sits directly downstream of the debouncer; consumes its filtered level output.
- Classifies the level into press, release, short-press and long-press events.
- Raises one-cycle event pulses, sticky write-1-to-clear status bits, a maskable interrupt and a press counter for the register block.

Parameters:
TICK_MS, 100000, clk cycles per 1 ms time base (100 MHz clock)
LT_W, 10, width of long-press threshold in ms

Ports:
clk  input  1  system clock, 100 MHz
res  input  1  reset, synchronous, active-high
ena  input  1  block enable
data_in  input  1  debounced button level (1 = pressed)
long_time  input  LT_W  long-press threshold in ms; 0 disables long detection
irq_mask  input  4  per-event interrupt enable, bit order as evt_status
evt_clr  input  4  write-1-to-clear strobes for evt_status
cnt_clr  input  1  clears press_cnt
press_pulse  output  1  1-cycle pulse on accepted press
release_pulse  output  1  1-cycle pulse on release
short_pulse  output  1  1-cycle pulse on release before long threshold
long_pulse  output  1  1-cycle pulse when threshold reached while held
evt_status  output  4  sticky flags [0]press [1]release [2]short [3]long
press_cnt  output  8  number of accepted presses, wraps 255->0
irq  output  1  |(evt_status & irq_mask)

Behaviour:
- Interface decision: one clock (clk); reset res is synchronous and active-high.
- Reset: all outputs 0, FSM = IDLE, tick_cnt = 0, ms_cnt = 0, prev_s = 0.
- Edge detection:
  - prev_s <= data_in every cycle, regardless of ena.
  - rise = data_in & ~prev_s; fall = ~data_in & prev_s.
- Registered outputs:
  - All pulses and status updates take effect on the clock edge that samples the edge condition.
  - Pulses are high for exactly the following cycle.
- ena = 0:
  - FSM forced to IDLE; tick_cnt and ms_cnt cleared; no pulses generated.
  - evt_status, press_cnt and irq hold their values; clears still work.
  - Enabling while data_in = 1 gives no press, because prev_s already tracks the level.
- FSM (evaluated only when ena = 1):
  - IDLE: on rise -> PRESSED; press_pulse = 1; tick_cnt = 0; ms_cnt = 0; press_cnt + 1.
  - PRESSED, fall -> IDLE; release_pulse = 1 and short_pulse = 1 together.
  - PRESSED, no fall:
    - tick_cnt increments.
    - At tick_cnt == TICK_MS-1: tick_cnt <= 0 and ms_cnt <= ms_cnt + 1.
    - If long_time != 0 and ms_cnt + 1 == long_time -> LONG_HELD with long_pulse = 1.
    - Net effect: long_pulse is registered long_time*TICK_MS cycles after the press edge.
  - PRESSED with long_time == 0: never goes long; ms_cnt saturates at all-ones; tick_cnt keeps wrapping.
  - LONG_HELD: on fall -> IDLE; release_pulse = 1 only (no short_pulse); counters idle.
  - Fall on the same edge as the threshold: fall wins -> short and release, no long.
  - long_time changed mid-press: compared live. If the new value is already passed, no long event occurs for this press.
- evt_status:
  - Bit set on the edge its pulse is generated.
  - Cleared when the matching evt_clr bit = 1.
  - Set and clear on the same edge: set wins.
- press_cnt:
  - 8-bit, wraps 255 -> 0.
  - cnt_clr forces 0.
  - cnt_clr together with a press: result = 1.
- irq: combinational from the registered evt_status and irq_mask; no extra latency beyond the status register.
- Reset mid-press: returns to IDLE with prev_s = 0. If data_in is still 1 after reset releases, a new press is detected on the next enabled cycle.

Test Plan:
- Short press: TICK_MS=4, long_time=3, ena=1, data_in 0->1 for 5 cycles then 0.
  -> press_pulse 1 cycle after rise; release_pulse and short_pulse together after fall; evt_status=0111; press_cnt=1; long_pulse never.
- Long press: same parameters, hold data_in high 20 cycles.
  -> long_pulse registered exactly 12 cycles after the press edge; on release only release_pulse; evt_status bit3=1, bit2=0.
- Boundary: release on the cycle the threshold would fire (held exactly 12 cycles).
  -> short_pulse=1, long_pulse=0.
  - Also long_time=0, held 100 cycles -> no long_pulse; short on release.
- Status/irq: irq_mask=1000, generate long press -> irq=1.
  - Pulse evt_clr=1000 on the same edge as a new long event -> bit stays 1.
  - Next evt_clr pulse clears it -> irq=0.
- Enable gating: data_in held 1, then ena 0->1 -> no press_pulse.
  - Press with ena=0 -> no pulses; press_cnt unchanged.
- Counter wrap and reset: 256 presses -> press_cnt=0.
  - cnt_clr with a press -> 1.
  - res asserted mid-press -> all outputs 0 next cycle.
  - data_in still 1 after release of res -> press_pulse once.

Source files
------------

// File: rtl/button_event.sv
// Button event classifier.
// Takes the debounced button level and turns it into press, release, short-press and
// long-press events. Each event raises a one-cycle pulse and sets a sticky status bit
// (write-1-to-clear). A maskable interrupt and an 8-bit press counter are also provided.
//
// Ports:
//   clk           system clock
//   res           synchronous active-high reset
//   ena           block enable; when low the classifier idles, status and counter hold
//   data_in       debounced button level (1 = pressed)
//   long_time     long-press threshold in ms; 0 disables long detection
//   irq_mask      per-event interrupt enable, same bit order as evt_status
//   evt_clr       write-1-to-clear strobes for evt_status
//   cnt_clr       clears press_cnt
//   press_pulse   one-cycle pulse on an accepted press
//   release_pulse one-cycle pulse on release
//   short_pulse   one-cycle pulse on release before the long threshold
//   long_pulse    one-cycle pulse when the threshold is reached while held
//   evt_status    sticky flags [0]press [1]release [2]short [3]long
//   press_cnt     accepted press count, wraps 255 -> 0
//   irq           |(evt_status & irq_mask)
module button_event #(
  parameter int unsigned TICK_MS = 100000,
  parameter int unsigned LT_W    = 10
) (
  input  logic            clk,
  input  logic            res,
  input  logic            ena,
  input  logic            data_in,
  input  logic [LT_W-1:0] long_time,
  input  logic [3:0]      irq_mask,
  input  logic [3:0]      evt_clr,
  input  logic            cnt_clr,
  output logic            press_pulse,
  output logic            release_pulse,
  output logic            short_pulse,
  output logic            long_pulse,
  output logic [3:0]      evt_status,
  output logic [7:0]      press_cnt,
  output logic            irq
);

  localparam int unsigned TW = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;
  localparam logic [TW-1:0] TickLast = TW'(TICK_MS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLongHeld
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick, w_tick_nxt;
  logic [LT_W-1:0] r_ms, w_ms_nxt;
  logic            r_prev_s;
  logic            r_press, r_release, r_short, r_long;
  logic            w_press, w_release, w_short, w_long;
  logic [3:0]      r_status, w_status_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;

  logic            w_rise, w_fall;
  logic [LT_W:0]   w_ms_inc;

  assign w_rise   = data_in & ~r_prev_s;
  assign w_fall   = ~data_in & r_prev_s;
  // One bit wider so a saturated ms count can never alias onto a small threshold.
  assign w_ms_inc = {1'b0, r_ms} + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_ms_nxt    = r_ms;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    if (!ena) begin
      w_state_nxt = StIdle;
      w_tick_nxt  = '0;
      w_ms_nxt    = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_rise) begin
            w_state_nxt = StPressed;
            w_press     = 1'b1;
            w_tick_nxt  = '0;
            w_ms_nxt    = '0;
          end
        end
        StPressed: begin
          // A release coinciding with the threshold counts as a short press.
          if (w_fall) begin
            w_state_nxt = StIdle;
            w_release   = 1'b1;
            w_short     = 1'b1;
          end else if (r_tick == TickLast) begin
            w_tick_nxt = '0;
            if (r_ms != {LT_W{1'b1}}) begin
              w_ms_nxt = r_ms + 1'b1;
            end
            // Live compare: a threshold lowered below the elapsed time never fires.
            if ((long_time != '0) && (w_ms_inc == {1'b0, long_time})) begin
              w_state_nxt = StLongHeld;
              w_long      = 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        StLongHeld: begin
          if (w_fall) begin
            w_state_nxt = StIdle;
            w_release   = 1'b1;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Set beats clear when both land on the same edge.
  always_comb begin
    w_status_nxt = (r_status & ~evt_clr) | {w_long, w_short, w_release, w_press};
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (cnt_clr) begin
      w_cnt_nxt = {7'd0, w_press};
    end else if (w_press) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state   <= StIdle;
      r_tick    <= '0;
      r_ms      <= '0;
      r_prev_s  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_status  <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_ms      <= w_ms_nxt;
      r_prev_s  <= data_in;
      r_press   <= w_press;
      r_release <= w_release;
      r_short   <= w_short;
      r_long    <= w_long;
      r_status  <= w_status_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign short_pulse   = r_short;
  assign long_pulse    = r_long;
  assign evt_status    = r_status;
  assign press_cnt     = r_cnt;
  assign irq           = |(r_status & irq_mask);

endmodule

// File: tb/tb_button_event.sv
// Directed self-checking bench for button_event with TICK_MS=4, LT_W=10.
module tb_button_event;

  localparam int unsigned TICK_MS = 4;
  localparam int unsigned LT_W    = 10;

  logic            clk = 1'b0;
  logic            res;
  logic            ena;
  logic            data_in;
  logic [LT_W-1:0] long_time;
  logic [3:0]      irq_mask;
  logic [3:0]      evt_clr;
  logic            cnt_clr;
  logic            press_pulse, release_pulse, short_pulse, long_pulse;
  logic [3:0]      evt_status;
  logic [7:0]      press_cnt;
  logic            irq;

  int total = 0;
  int bad   = 0;
  int seen;

  button_event #(
    .TICK_MS(TICK_MS),
    .LT_W   (LT_W)
  ) dut (
    .clk          (clk),
    .res          (res),
    .ena          (ena),
    .data_in      (data_in),
    .long_time    (long_time),
    .irq_mask     (irq_mask),
    .evt_clr      (evt_clr),
    .cnt_clr      (cnt_clr),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .evt_status   (evt_status),
    .press_cnt    (press_cnt),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_status();
    evt_clr = 4'hF;
    step();
    evt_clr = 4'h0;
  endtask

  initial begin
    res = 1'b1; ena = 1'b1; data_in = 1'b0; long_time = 10'd3;
    irq_mask = 4'h0; evt_clr = 4'h0; cnt_clr = 1'b0;
    step(); step();
    check("reset_pulses", {press_pulse, release_pulse, short_pulse, long_pulse}, 0);
    check("reset_status", evt_status, 0);
    check("reset_cnt", press_cnt, 0);
    check("reset_irq", irq, 0);
    res = 1'b0;
    step();

    // Short press: high for 5 cycles.
    data_in = 1'b1;
    step();
    check("short_press_pulse", press_pulse, 1);
    check("short_press_cnt", press_cnt, 1);
    step();
    check("short_press_pulse_width", press_pulse, 0);
    seen = 0;
    repeat (3) begin step(); seen += int'(long_pulse); end
    data_in = 1'b0;
    step();
    check("short_release", release_pulse, 1);
    check("short_short", short_pulse, 1);
    check("short_status", evt_status, 4'b0111);
    check("short_no_long", seen + int'(long_pulse), 0);
    step();
    check("short_release_width", {release_pulse, short_pulse}, 0);
    clear_status();
    check("status_cleared", evt_status, 0);

    // Long press: 20 cycles, long at edge 12 after press.
    data_in = 1'b1;
    step();
    check("long_press_pulse", press_pulse, 1);
    seen = 0;
    for (int i = 1; i <= 11; i++) begin step(); seen += int'(long_pulse); end
    check("long_not_early", seen, 0);
    step();
    check("long_pulse_at_12", long_pulse, 1);
    check("long_status", evt_status, 4'b1001);
    step();
    check("long_pulse_width", long_pulse, 0);
    repeat (6) step();
    data_in = 1'b0;
    step();
    check("long_release", release_pulse, 1);
    check("long_no_short", short_pulse, 0);
    check("long_status_rel", evt_status, 4'b1011);
    check("long_cnt", press_cnt, 2);
    clear_status();

    // Release exactly on the threshold edge.
    data_in = 1'b1;
    step();
    repeat (11) step();
    data_in = 1'b0;
    step();
    check("bound_short", short_pulse, 1);
    check("bound_release", release_pulse, 1);
    check("bound_no_long", long_pulse, 0);
    check("bound_status", evt_status, 4'b0111);
    clear_status();

    // long_time = 0 disables long detection.
    long_time = 10'd0;
    data_in = 1'b1;
    step();
    seen = 0;
    repeat (100) begin step(); seen += int'(long_pulse); end
    data_in = 1'b0;
    step();
    check("lt0_no_long", seen + int'(long_pulse), 0);
    check("lt0_short", short_pulse, 1);
    check("lt0_cnt", press_cnt, 4);
    long_time = 10'd3;
    clear_status();

    // Interrupt on long, clear colliding with a new long event.
    irq_mask = 4'b1000;
    check("irq_idle", irq, 0);
    data_in = 1'b1;
    step();
    repeat (12) step();
    check("irq_long", irq, 1);
    data_in = 1'b0;
    step();
    data_in = 1'b1;
    step();
    repeat (11) step();
    evt_clr = 4'b1000;
    step();
    evt_clr = 4'b0000;
    check("setwins_long", long_pulse, 1);
    check("setwins_bit", evt_status[3], 1);
    check("setwins_irq", irq, 1);
    data_in = 1'b0;
    step();
    evt_clr = 4'b1000;
    step();
    evt_clr = 4'b0000;
    check("clr_bit", evt_status[3], 0);
    check("clr_irq", irq, 0);
    check("irq_cnt", press_cnt, 6);

    // Enabling while held gives no press.
    clear_status();
    ena = 1'b0;
    data_in = 1'b1;
    seen = 0;
    repeat (2) begin step(); seen += int'(press_pulse); end
    ena = 1'b1;
    repeat (3) begin step(); seen += int'(press_pulse); end
    check("ena_held_no_press", seen, 0);
    data_in = 1'b0;
    step();
    check("ena_held_no_release", release_pulse, 0);
    // Press while disabled.
    ena = 1'b0;
    data_in = 1'b1;
    seen = 0;
    repeat (3) begin step(); seen += int'(press_pulse | long_pulse); end
    data_in = 1'b0;
    step();
    check("dis_no_pulses", seen + int'(release_pulse | short_pulse), 0);
    check("dis_cnt", press_cnt, 6);
    check("dis_status", evt_status, 0);
    ena = 1'b1;
    step();

    // Counter wrap.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("cnt_clr", press_cnt, 0);
    repeat (255) begin
      data_in = 1'b1; step();
      data_in = 1'b0; step();
    end
    check("cnt_255", press_cnt, 255);
    data_in = 1'b1; step();
    data_in = 1'b0; step();
    check("cnt_wrap", press_cnt, 0);
    data_in = 1'b1;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("cnt_clr_press", press_cnt, 1);
    check("cnt_clr_press_pulse", press_pulse, 1);

    // Reset mid-press, button still held afterwards.
    irq_mask = 4'hF;
    repeat (3) step();
    check("pre_reset_irq", irq, 1);
    res = 1'b1;
    step();
    res = 1'b0;
    check("rst_pulses", {press_pulse, release_pulse, short_pulse, long_pulse}, 0);
    check("rst_status", evt_status, 0);
    check("rst_cnt", press_cnt, 0);
    check("rst_irq", irq, 0);
    step();
    check("rst_repress", press_pulse, 1);
    check("rst_repress_cnt", press_cnt, 1);
    seen = 0;
    repeat (3) begin step(); seen += int'(press_pulse); end
    check("rst_repress_once", seen, 0);
    data_in = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
